// File: rtl/cdb_arb_pkg.sv
// Shared defaults, broadcast packet type and ROB age comparison for the CDB arbiter.
// Consumers: cdb_req_buf, cdb_arbiter.
package cdb_arb_pkg;

    localparam int unsigned N_REQ_DEF  = 3;
    localparam int unsigned PREG_W_DEF = 7;
    localparam int unsigned ROB_W_DEF  = 4;
    localparam int unsigned TAG_W_MAX  = 16;

    typedef struct packed {
        logic [PREG_W_DEF-1:0] pd;
        logic [31:0]           data;
        logic [ROB_W_DEF-1:0]  rob_tag;
    } cdb_pkt_t;

    // Ages are measured from the ROB head modulo 2^rob_w; a tag equal to the
    // branch tag has equal age and is therefore never considered younger.
    function automatic logic tag_younger(
        input logic [TAG_W_MAX-1:0] tag,
        input logic [TAG_W_MAX-1:0] flush_tag,
        input logic [TAG_W_MAX-1:0] head,
        input int unsigned          rob_w
    );
        logic [TAG_W_MAX-1:0] mask;
        mask = TAG_W_MAX'((33'd1 << rob_w) - 33'd1);
        return ((tag - head) & mask) > ((flush_tag - head) & mask);
    endfunction

endpackage

// File: rtl/cdb_req_buf.sv
// Two-slot writeback buffer for one CDB requester, with insertion-order head
// selection and mispredict kill of younger entries.
module cdb_req_buf
    import cdb_arb_pkg::*;
#(
    parameter int unsigned PREG_W = PREG_W_DEF,
    parameter int unsigned ROB_W  = ROB_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PREG_W-1:0] in_pd,
    input  logic [31:0]       in_data,
    input  logic [ROB_W-1:0]  in_rob_tag,
    input  logic              pop,
    input  logic              flush,
    input  logic [ROB_W-1:0]  flush_rob_tag,
    input  logic [ROB_W-1:0]  rob_head,
    output logic              head_valid,
    output logic [PREG_W-1:0] head_pd,
    output logic [31:0]       head_data,
    output logic [ROB_W-1:0]  head_rob_tag
);

    logic [1:0]        slot_valid;
    logic [1:0]        slot_ord;
    logic [1:0]        nxt_valid;
    logic [1:0]        nxt_ord;
    logic [1:0]        kill;
    logic              in_kill;
    logic              push;
    logic              head_idx;
    logic              free_idx;
    logic [PREG_W-1:0] slot_pd   [2];
    logic [31:0]       slot_data [2];
    logic [ROB_W-1:0]  slot_tag  [2];

    assign in_ready   = ~(slot_valid[0] & slot_valid[1]);
    assign head_valid = |slot_valid;
    // slot_ord[i] set means slot i was written after the other (still valid) slot
    assign head_idx   = (slot_valid[0] & slot_valid[1]) ? slot_ord[0] : slot_valid[1];
    assign free_idx   = slot_valid[0];

    assign head_pd      = slot_pd[head_idx];
    assign head_data    = slot_data[head_idx];
    assign head_rob_tag = slot_tag[head_idx];

    always_comb begin
        kill[0] = flush & tag_younger(TAG_W_MAX'(slot_tag[0]), TAG_W_MAX'(flush_rob_tag),
                                      TAG_W_MAX'(rob_head), ROB_W);
        kill[1] = flush & tag_younger(TAG_W_MAX'(slot_tag[1]), TAG_W_MAX'(flush_rob_tag),
                                      TAG_W_MAX'(rob_head), ROB_W);
        in_kill = flush & tag_younger(TAG_W_MAX'(in_rob_tag), TAG_W_MAX'(flush_rob_tag),
                                      TAG_W_MAX'(rob_head), ROB_W);
        push      = in_valid & in_ready & ~in_kill;
        nxt_valid = slot_valid;
        nxt_ord   = slot_ord;

        if (pop)
            nxt_valid[head_idx] = 1'b0;
        nxt_valid = nxt_valid & ~kill;

        // A lone survivor becomes the oldest entry again.
        if (!nxt_valid[1])
            nxt_ord[0] = 1'b0;
        if (!nxt_valid[0])
            nxt_ord[1] = 1'b0;

        if (push) begin
            nxt_valid[free_idx] = 1'b1;
            nxt_ord[free_idx]   = nxt_valid[~free_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid <= '0;
            slot_ord   <= '0;
        end else begin
            slot_valid <= nxt_valid;
            slot_ord   <= nxt_ord;
            if (push) begin
                slot_pd[free_idx]   <= in_pd;
                slot_data[free_idx] <= in_data;
                slot_tag[free_idx]  <= in_rob_tag;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus writeback arbiter: per-requester 2-slot buffers, one registered
// broadcast per cycle. Define CDB_ARB_FIXED_PRIO_EN for fixed priority (index 0 wins).
module cdb_arbiter
    import cdb_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = N_REQ_DEF,
    parameter int unsigned PREG_W = PREG_W_DEF,
    parameter int unsigned ROB_W  = ROB_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0][PREG_W-1:0] req_pd,
    input  logic [N_REQ-1:0][31:0]       req_data,
    input  logic [N_REQ-1:0][ROB_W-1:0]  req_rob_tag,
    input  logic                         flush,
    input  logic [ROB_W-1:0]             flush_rob_tag,
    input  logic [ROB_W-1:0]             rob_head,
    output logic                         cdb_valid,
    output logic [PREG_W-1:0]            cdb_pd,
    output logic [31:0]                  cdb_data,
    output logic [ROB_W-1:0]             cdb_rob_tag
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  cand;
    logic [N_REQ-1:0]  pop;
    logic [PREG_W-1:0] head_pd   [N_REQ];
    logic [31:0]       head_data [N_REQ];
    logic [ROB_W-1:0]  head_tag  [N_REQ];
    logic              grant_any;
    logic [PTR_W-1:0]  winner;
    logic              win_kill;

    for (genvar g = 0; g < N_REQ; g++) begin : g_buf
        cdb_req_buf #(
            .PREG_W (PREG_W),
            .ROB_W  (ROB_W)
        ) u_buf (
            .clk           (clk),
            .reset         (reset),
            .in_valid      (req_valid[g]),
            .in_ready      (req_ready[g]),
            .in_pd         (req_pd[g]),
            .in_data       (req_data[g]),
            .in_rob_tag    (req_rob_tag[g]),
            .pop           (pop[g]),
            .flush         (flush),
            .flush_rob_tag (flush_rob_tag),
            .rob_head      (rob_head),
            .head_valid    (cand[g]),
            .head_pd       (head_pd[g]),
            .head_data     (head_data[g]),
            .head_rob_tag  (head_tag[g])
        );
        assign pop[g] = grant_any & (winner == PTR_W'(g));
    end

`ifdef CDB_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!grant_any && cand[k]) begin
                grant_any = 1'b1;
                winner    = PTR_W'(k);
            end
        end
    end
`else
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_idx;

    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        rr_idx    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            rr_idx = PTR_W'((32'(rr_ptr) + k) % N_REQ);
            if (!grant_any && cand[rr_idx]) begin
                grant_any = 1'b1;
                winner    = rr_idx;
            end
        end
    end

    // Pointer advances on every grant, including one whose result a flush discards.
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= '0;
        else if (grant_any)
            rr_ptr <= (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + PTR_W'(1);
    end
`endif

    assign win_kill = flush & tag_younger(TAG_W_MAX'(head_tag[winner]), TAG_W_MAX'(flush_rob_tag),
                                          TAG_W_MAX'(rob_head), ROB_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            cdb_valid   <= 1'b0;
            cdb_pd      <= '0;
            cdb_data    <= '0;
            cdb_rob_tag <= '0;
        end else if (grant_any) begin
            cdb_valid   <= ~win_kill;
            cdb_pd      <= head_pd[winner];
            cdb_data    <= head_data[winner];
            cdb_rob_tag <= head_tag[winner];
        end else begin
            cdb_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// against a queue-level reference model. Honours CDB_ARB_FIXED_PRIO_EN.
module tb_cdb_arbiter;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      req_valid;
    logic [2:0]      req_ready;
    logic [2:0][6:0] req_pd;
    logic [2:0][31:0] req_data;
    logic [2:0][3:0] req_rob_tag;
    logic            flush;
    logic [3:0]      flush_rob_tag;
    logic [3:0]      rob_head;
    logic            cdb_valid;
    logic [6:0]      cdb_pd;
    logic [31:0]     cdb_data;
    logic [3:0]      cdb_rob_tag;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-requester lists in arrival order plus expected output register.
    logic [6:0]  mpd   [3][2];
    logic [31:0] mdata [3][2];
    logic [3:0]  mtag  [3][2];
    int          mcnt  [3];
    int          m_rr;
    logic        m_cv;
    logic [6:0]  m_cpd;
    logic [31:0] m_cdata;
    logic [3:0]  m_ctag;

    cdb_arbiter #(
        .N_REQ  (3),
        .PREG_W (7),
        .ROB_W  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_pd        (req_pd),
        .req_data      (req_data),
        .req_rob_tag   (req_rob_tag),
        .flush         (flush),
        .flush_rob_tag (flush_rob_tag),
        .rob_head      (rob_head),
        .cdb_valid     (cdb_valid),
        .cdb_pd        (cdb_pd),
        .cdb_data      (cdb_data),
        .cdb_rob_tag   (cdb_rob_tag)
    );

    always #5 clk = ~clk;

    function automatic bit tb_younger(input logic [3:0] t);
        int at;
        int af;
        at = (int'(t) - int'(rob_head) + 16) % 16;
        af = (int'(flush_rob_tag) - int'(rob_head) + 16) % 16;
        return at > af;
    endfunction

    function automatic logic [2:0] m_ready();
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = (mcnt[i] < 2);
        return r;
    endfunction

    task automatic drop(input int r, input int j);
        for (int k = j; k < 1; k++) begin
            mpd[r][k]   = mpd[r][k+1];
            mdata[r][k] = mdata[r][k+1];
            mtag[r][k]  = mtag[r][k+1];
        end
        mcnt[r]--;
    endtask

    task automatic model_edge();
        logic [2:0] rdy;
        int w;
        if (reset) begin
            for (int i = 0; i < 3; i++) mcnt[i] = 0;
            m_rr = 0; m_cv = 1'b0; m_cpd = '0; m_cdata = '0; m_ctag = '0;
            return;
        end
        rdy = m_ready();
        w = -1;
        for (int k = 0; k < 3; k++) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
            int i = k;
`else
            int i = (m_rr + k) % 3;
`endif
            if (w < 0 && mcnt[i] > 0) w = i;
        end
        if (w >= 0) begin
            m_cpd   = mpd[w][0];
            m_cdata = mdata[w][0];
            m_ctag  = mtag[w][0];
            m_cv    = !(flush && tb_younger(mtag[w][0]));
            drop(w, 0);
            m_rr = (w + 1) % 3;
        end else begin
            m_cv = 1'b0;
        end
        if (flush)
            for (int i = 0; i < 3; i++)
                for (int j = mcnt[i] - 1; j >= 0; j--)
                    if (tb_younger(mtag[i][j])) drop(i, j);
        for (int i = 0; i < 3; i++)
            if (req_valid[i] && rdy[i] && !(flush && tb_younger(req_rob_tag[i]))) begin
                mpd[i][mcnt[i]]   = req_pd[i];
                mdata[i][mcnt[i]] = req_data[i];
                mtag[i][mcnt[i]]  = req_rob_tag[i];
                mcnt[i]++;
            end
    endtask

    // Inputs are set at the falling edge; outputs are sampled at the next falling edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset = 1'b0; req_valid = '0; flush = 1'b0; flush_rob_tag = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        rob_head = '0;
        req_pd = '0; req_data = '0; req_rob_tag = '0;
        @(negedge clk);
        reset = 1'b1; req_valid = 3'b111; flush = 1'b1; flush_rob_tag = 4'd0;
        req_data[0] = 32'hDEAD_0001; req_rob_tag[0] = 4'd9;
        tick();
        idle_inputs();
        checks++;
        if (cdb_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b want 0", cdb_valid);
        end
        checks++;
        if ({cdb_pd, cdb_data, cdb_rob_tag} !== 43'd0) begin
            failures++; $display("FAIL reset_payload: got %h want 0", {cdb_pd, cdb_data, cdb_rob_tag});
        end
        checks++;
        if (req_ready !== 3'b111) begin
            failures++; $display("FAIL reset_ready: got %b want 111", req_ready);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b0) begin
            failures++; $display("FAIL reset_no_broadcast: got %b want 0", cdb_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        rob_head = 4'd0;
        req_valid = 3'b010; req_pd[1] = 7'd12; req_data[1] = 32'h0000_00AA; req_rob_tag[1] = 4'd3;
        tick();
        req_valid = '0;
        checks++;
        if (cdb_valid !== 1'b0) begin
            failures++; $display("FAIL single_n1: cdb_valid got %b want 0", cdb_valid);
        end
        tick();
        checks++;
        if ({cdb_valid, cdb_pd, cdb_data, cdb_rob_tag} !== {1'b1, 7'd12, 32'h0000_00AA, 4'd3}) begin
            failures++;
            $display("FAIL single_n2: got v=%b pd=%0d data=%h tag=%0d want v=1 pd=12 data=000000aa tag=3",
                     cdb_valid, cdb_pd, cdb_data, cdb_rob_tag);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b0) begin
            failures++; $display("FAIL single_n3: cdb_valid got %b want 0", cdb_valid);
        end
    endtask

    task automatic test_contention();
        int exp_src;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req_valid = 3'b111;
            for (int i = 0; i < 3; i++) begin
                req_pd[i] = 7'(i * 10 + c); req_data[i] = {4'(i), 28'(c)}; req_rob_tag[i] = 4'(c);
            end
            tick();
            checks++;
            if (req_ready !== m_ready()) begin
                failures++; $display("FAIL contention_ready c=%0d: got %b want %b", c, req_ready, m_ready());
            end
            if (c >= 1) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
                exp_src = 0;
`else
                exp_src = (c - 1) % 3;
`endif
                checks++;
                if (cdb_valid !== 1'b1 || int'(cdb_data[31:28]) != exp_src || cdb_data !== m_cdata) begin
                    failures++;
                    $display("FAIL contention_grant c=%0d: got v=%b data=%h want v=1 src=%0d data=%h",
                             c, cdb_valid, cdb_data, exp_src, m_cdata);
                end
            end
        end
        checks++;
`ifdef CDB_ARB_FIXED_PRIO_EN
        if (req_ready !== 3'b001) begin
            failures++; $display("FAIL contention_ready_final: got %b want 001", req_ready);
        end
`else
        if (req_ready === 3'b111) begin
            failures++; $display("FAIL contention_ready_final: got %b want some ready low", req_ready);
        end
`endif
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        rob_head = 4'd14;
        req_valid = 3'b111;
        req_pd[0] = 7'd1; req_data[0] = 32'h15; req_rob_tag[0] = 4'd15;
        req_pd[1] = 7'd2; req_data[1] = 32'h01; req_rob_tag[1] = 4'd1;
        req_pd[2] = 7'd3; req_data[2] = 32'h03; req_rob_tag[2] = 4'd3;
        tick();
        req_valid = '0; flush = 1'b1; flush_rob_tag = 4'd1;
        tick();
        flush = 1'b0;
        checks++;
        if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'd15 || cdb_pd !== 7'd1) begin
            failures++; $display("FAIL flush_keep15: got v=%b tag=%0d want v=1 tag=15", cdb_valid, cdb_rob_tag);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'd1 || cdb_pd !== 7'd2) begin
            failures++; $display("FAIL flush_keep1: got v=%b tag=%0d want v=1 tag=1", cdb_valid, cdb_rob_tag);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (cdb_valid !== 1'b0) begin
                failures++; $display("FAIL flush_drop3 c=%0d: got v=%b tag=%0d want v=0", c, cdb_valid, cdb_rob_tag);
            end
        end
        // Winner killed in its grant cycle; branch's own tag arriving with the flush survives.
        do_reset();
        rob_head = 4'd0;
        req_valid = 3'b100; req_pd[2] = 7'd50; req_data[2] = 32'h5; req_rob_tag[2] = 4'd5;
        tick();
        req_valid = 3'b011; flush = 1'b1; flush_rob_tag = 4'd2;
        req_pd[0] = 7'd20; req_data[0] = 32'h2; req_rob_tag[0] = 4'd2;
        req_pd[1] = 7'd70; req_data[1] = 32'h7; req_rob_tag[1] = 4'd7;
        tick();
        idle_inputs();
        checks++;
        if (cdb_valid !== 1'b0) begin
            failures++; $display("FAIL flush_grant_kill: got v=%b tag=%0d want v=0", cdb_valid, cdb_rob_tag);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'd2 || cdb_pd !== 7'd20) begin
            failures++; $display("FAIL flush_own_tag: got v=%b tag=%0d want v=1 tag=2", cdb_valid, cdb_rob_tag);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b0) begin
            failures++; $display("FAIL flush_incoming_kill: got v=%b tag=%0d want v=0", cdb_valid, cdb_rob_tag);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            req_valid = 3'b111;
            for (int i = 0; i < 3; i++) begin
                req_pd[i] = 7'(c + 1); req_data[i] = 32'(100 + c); req_rob_tag[i] = 4'(c);
            end
            tick();
        end
        checks++;
        if (mcnt[0] + mcnt[1] + mcnt[2] < 4) begin
            failures++; $display("FAIL midstream_fill: got %0d buffered want >=4", mcnt[0] + mcnt[1] + mcnt[2]);
        end
        reset = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (req_ready !== 3'b111) begin
            failures++; $display("FAIL midstream_ready: got %b want 111", req_ready);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (cdb_valid !== 1'b0) begin
                failures++; $display("FAIL midstream_stale c=%0d: got v=%b data=%h want v=0", c, cdb_valid, cdb_data);
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset         = ($urandom_range(0, 99) == 0);
            req_valid     = 3'($urandom);
            rob_head      = 4'($urandom);
            flush         = ($urandom_range(0, 7) == 0);
            flush_rob_tag = 4'($urandom);
            for (int i = 0; i < 3; i++) begin
                req_pd[i] = 7'($urandom); req_data[i] = $urandom; req_rob_tag[i] = 4'($urandom);
            end
            tick();
            checks++;
            if (req_ready !== m_ready()) begin
                failures++; $display("FAIL random_ready c=%0d: got %b want %b", c, req_ready, m_ready());
            end
            checks++;
            if (cdb_valid !== m_cv) begin
                failures++; $display("FAIL random_valid c=%0d: got %b want %b", c, cdb_valid, m_cv);
            end else if (m_cv) begin
                checks++;
                if ({cdb_pd, cdb_data, cdb_rob_tag} !== {m_cpd, m_cdata, m_ctag}) begin
                    failures++;
                    $display("FAIL random_payload c=%0d: got pd=%0d data=%h tag=%0d want pd=%0d data=%h tag=%0d",
                             c, cdb_pd, cdb_data, cdb_rob_tag, m_cpd, m_cdata, m_ctag);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; flush = 1'b0; flush_rob_tag = '0; rob_head = '0;
        req_pd = '0; req_data = '0; req_rob_tag = '0;
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
        m_rr = 0; m_cv = 1'b0; m_cpd = '0; m_cdata = '0; m_ctag = '0;
        test_reset();
        test_single();
        test_contention();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
